// File: rtl/qu_common_pkg.sv
// Shared Qu core types: writeback entry layout and default writeback port count.
package qu_common;

    localparam int PHY_RF_ADDR_WIDTH = 6;
    localparam int QU_WB_NUM_PORTS   = 3;

    typedef struct packed {
        logic [PHY_RF_ADDR_WIDTH-1:0] addr;
        logic [31:0]                  data;
    } wb_entry_t;

endpackage

// File: rtl/qu_wb_fifo.sv
// Per-port result buffer: synchronous FIFO with full/empty/count; clear empties it.
module qu_wb_fifo
    import qu_common::*;
#(
    parameter type entry_t = wb_entry_t,
    parameter int  DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  entry_t                 din,
    output entry_t                 dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/qu_wb_arbiter.sv
// Qu writeback arbiter: per-port result buffers feeding the single registered RF write port.
// QU_WB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise lowest port index wins.
module qu_wb_arbiter
    import qu_common::*;
#(
    parameter int NUM_PORTS  = QU_WB_NUM_PORTS,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = PHY_RF_ADDR_WIDTH,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic                                 wb_stall,
    input  logic [NUM_PORTS-1:0]                 eu_valid_in,
    output logic [NUM_PORTS-1:0]                 eu_ready_out,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] eu_addr_in,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] eu_data_in,
    output logic                                 rf_wr_en,
    output logic [ADDR_WIDTH-1:0]                rf_rd_addr,
    output logic [DATA_WIDTH-1:0]                rf_data_out
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t               head  [NUM_PORTS];
    logic [CNT_W-1:0]     count [NUM_PORTS];
    logic [NUM_PORTS-1:0] full, empty, push, pop;
    logic                 clear;

    logic                 sel_found, grant;
    logic [IDX_W-1:0]     sel_idx;
    entry_t               sel_entry;
    int                   scan_idx;

    logic                  rf_wr_en_q, rf_wr_en_d;
    logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;

    assign clear = rst || flush;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        qu_wb_fifo #(
            .entry_t (entry_t),
            .DEPTH   (BUF_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .clear (clear),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   ({eu_addr_in[g], eu_data_in[g]}),
            .dout  (head[g]),
            .full  (full[g]),
            .empty (empty[g]),
            .count (count[g])
        );

        // Ready comes from the registered count only: no pass-through when full.
        assign eu_ready_out[g] = (count[g] < DEPTH_C);
        assign push[g]         = eu_valid_in[g] && !full[g];
    end

`ifdef QU_WB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_entry = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_PORTS) scan_idx = scan_idx - NUM_PORTS;
            if (!sel_found && !empty[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(scan_idx);
                sel_entry = head[scan_idx];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant) rr_ptr_d = (sel_idx == IDX_W'(NUM_PORTS-1)) ? '0 : sel_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end
`else
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_entry = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            scan_idx = k;
            if (!sel_found && !empty[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(scan_idx);
                sel_entry = head[scan_idx];
            end
        end
    end
`endif

    assign grant = sel_found && !wb_stall && !flush;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) pop[i] = grant && (sel_idx == IDX_W'(i));
    end

    // A grant to the zero register still consumes the entry but issues no write.
    always_comb begin
        rf_wr_en_d = grant && (sel_entry.addr != '0);
        rf_addr_d  = rf_addr_q;
        rf_data_d  = rf_data_q;
        if (rf_wr_en_d) begin
            rf_addr_d = sel_entry.addr;
            rf_data_d = sel_entry.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr_en_q <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
        end else begin
            rf_wr_en_q <= rf_wr_en_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
        end
    end

    assign rf_wr_en    = rf_wr_en_q;
    assign rf_rd_addr  = rf_addr_q;
    assign rf_data_out = rf_data_q;

endmodule

// File: tb/tb_qu_wb_arbiter.sv
// Randomized and directed bench for qu_wb_arbiter against a queue-based reference model.
module tb_qu_wb_arbiter;
    import qu_common::*;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = PHY_RF_ADDR_WIDTH;
    localparam int D  = 2;

    logic                 clk = 1'b0;
    logic                 rst, flush, wb_stall;
    logic [N-1:0]         eu_valid_in, eu_ready_out;
    logic [N-1:0][AW-1:0] eu_addr_in;
    logic [N-1:0][DW-1:0] eu_data_in;
    logic                 rf_wr_en;
    logic [AW-1:0]        rf_rd_addr;
    logic [DW-1:0]        rf_data_out;

    qu_wb_arbiter #(
        .NUM_PORTS  (N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BUF_DEPTH  (D)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wb_stall     (wb_stall),
        .eu_valid_in  (eu_valid_in),
        .eu_ready_out (eu_ready_out),
        .eu_addr_in   (eu_addr_in),
        .eu_data_in   (eu_data_in),
        .rf_wr_en     (rf_wr_en),
        .rf_rd_addr   (rf_rd_addr),
        .rf_data_out  (rf_data_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq [N][$];
    int            m_rr;
    logic          m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [AW-1:0] wlog [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (mq[i].size() < D);
        return r;
    endfunction

    // Reference behaviour of one clock edge, using the inputs as they stand at the edge.
    function automatic void model_edge();
        logic [N-1:0] acc;
        int           w;
        int           p;
        ent_t         e;
        acc = m_ready() & eu_valid_in;
        if (rst || flush) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_en = 1'b0;
            if (rst) begin
                m_addr = '0;
                m_data = '0;
                m_rr   = 0;
            end
            return;
        end
        m_en = 1'b0;
        if (!wb_stall) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
`ifdef QU_WB_ROUND_ROBIN_EN
                p = (m_rr + k) % N;
`else
                p = k;
`endif
                if (w < 0 && mq[p].size() > 0) w = p;
            end
            if (w >= 0) begin
                e = mq[w].pop_front();
                if (e.a != '0) begin
                    m_en   = 1'b1;
                    m_addr = e.a;
                    m_data = e.d;
                end
                m_rr = (w + 1) % N;
            end
        end
        for (int i = 0; i < N; i++)
            if (acc[i]) mq[i].push_back({eu_addr_in[i], eu_data_in[i]});
    endfunction

    task automatic tick();
        check_val("ready", eu_ready_out, m_ready());
        @(posedge clk);
        model_edge();
        #1;
        check_val("wr_en", rf_wr_en, m_en);
        check_val("rd_addr", rf_rd_addr, m_addr);
        check_val("data", rf_data_out, m_data);
        if (rf_wr_en === 1'b1) wlog.push_back(rf_rd_addr);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        eu_valid_in = '0;
        wb_stall    = 1'b0;
        flush       = 1'b0;
        rst         = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        eu_addr_in[p] = a;
        eu_data_in[p] = d;
    endtask

    int accepted;

    initial begin
        rst = 1'b1; flush = 1'b0; wb_stall = 1'b0;
        eu_valid_in = '0; eu_addr_in = '0; eu_data_in = '0;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_val("rst_en", rf_wr_en, 1'b0);
        check_val("rst_addr", rf_rd_addr, '0);
        check_val("rst_data", rf_data_out, '0);
        check_val("rst_ready", eu_ready_out, 3'b111);
        rst = 1'b0;

        // Latency: single push on port 1.
        set_port(1, 6'd5, 32'hDEADBEEF);
        eu_valid_in = 3'b010;
        tick();
        eu_valid_in = '0;
        tick();
        check_val("lat_en", rf_wr_en, 1'b1);
        check_val("lat_addr", rf_rd_addr, 6'd5);
        check_val("lat_data", rf_data_out, 32'hDEADBEEF);
        tick();
        check_val("lat_pulse", rf_wr_en, 1'b0);

        // All ports continuously valid.
        rst = 1'b1; tick(); rst = 1'b0;
        wlog.delete();
        for (int p = 0; p < N; p++) set_port(p, AW'(10 + p), $urandom);
        eu_valid_in = 3'b111;
        for (int i = 0; i < 9; i++) tick();
        idle(8);
        check_val("arb_cnt_ge6", (wlog.size() >= 6), 1'b1);
        for (int i = 0; i < 6 && i < wlog.size(); i++) begin
`ifdef QU_WB_ROUND_ROBIN_EN
            check_val("rr_order", wlog[i], AW'(10 + (i % N)));
`else
            check_val("fp_order", wlog[i], AW'(10));
`endif
        end

        // Stall while port 0 pushes three results.
        wlog.delete();
        wb_stall = 1'b1;
        accepted = 0;
        for (int i = 0; i < 4; i++) begin
            set_port(0, AW'(20 + accepted), 32'h100 + accepted);
            eu_valid_in = 3'b001;
            if (eu_ready_out[0]) accepted++;
            tick();
        end
        check_val("stall_acc", accepted, 2);
        check_val("stall_rdy0", eu_ready_out[0], 1'b0);
        wb_stall = 1'b0;
        for (int i = 0; i < 6 && accepted < 3; i++) begin
            set_port(0, AW'(20 + accepted), 32'h100 + accepted);
            eu_valid_in = 3'b001;
            if (eu_ready_out[0]) accepted++;
            tick();
        end
        idle(4);
        check_val("stall_n", wlog.size(), 3);
        for (int i = 0; i < 3 && i < wlog.size(); i++)
            check_val("stall_order", wlog[i], AW'(20 + i));

        // Zero-register destination followed by real writes.
        rst = 1'b1; tick(); rst = 1'b0;
        wlog.delete();
        set_port(0, '0, 32'h1234);
        set_port(1, 6'd7, 32'h77);
        set_port(2, 6'd8, 32'h88);
        eu_valid_in = 3'b111;
        tick();
        eu_valid_in = '0;
        tick();
        check_val("zero_en", rf_wr_en, 1'b0);
        check_val("zero_rdy", eu_ready_out, 3'b111);
        idle(4);
        check_val("zero_n", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check_val("zero_next", wlog[0], 6'd7);
            check_val("zero_last", wlog[1], 6'd8);
        end

        // Flush with buffered entries and a same-cycle push.
        wlog.delete();
        wb_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_port(0, AW'(30 + i), $urandom);
            set_port(2, AW'(40 + i), $urandom);
            eu_valid_in = 3'b101;
            tick();
        end
        check_val("pre_flush_rdy", eu_ready_out, 3'b010);
        wb_stall = 1'b0; flush = 1'b1;
        set_port(1, 6'd50, 32'h5050);
        eu_valid_in = 3'b010;
        tick();
        check_val("flush_en", rf_wr_en, 1'b0);
        check_val("flush_rdy", eu_ready_out, 3'b111);
        idle(4);
        check_val("flush_nowr", wlog.size(), 0);

        // Reset mid-stream.
        for (int p = 0; p < N; p++) set_port(p, AW'(1 + p), $urandom);
        eu_valid_in = 3'b111;
        tick(); tick();
        rst = 1'b1;
        tick();
        check_val("mrst_en", rf_wr_en, 1'b0);
        check_val("mrst_addr", rf_rd_addr, '0);
        check_val("mrst_data", rf_data_out, '0);
        wlog.delete();
        idle(4);
        check_val("mrst_nowr", wlog.size(), 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            eu_valid_in = N'($urandom);
            for (int p = 0; p < N; p++)
                set_port(p, ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom), $urandom);
            wb_stall = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 39) == 0);
            rst      = ($urandom_range(0, 149) == 0);
            tick();
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
